ioctl_sender: RTL and testbench
===============================

Name: ioctl_sender

Overview:
- Initiator side of the 16-bit wide ioctl download bus (WIDE=1 mode), i.e. the driving end of ioctl_download/ioctl_index/ioctl_wr/ioctl_addr/ioctl_dout/ioctl_wait.
- Takes a framed byte stream with a valid/ready handshake and packs it into little-endian 16-bit words. Issues single-cycle write strobes and honours ioctl_wait back-pressure.
- Lives in clk_sys. Used as the ROM loader for the simulation harness and for in-fabric self-load of ROM images.

Parameters:
- SETUP_CYCLES, 4: cycles ioctl_download is high before the first byte is accepted. Also the hold time after the last write.
- MIN_GAP, 2: minimum cycles from one ioctl_wr pulse to acceptance of the next word's first byte.
- PAD_BYTE, 8'h00: high byte used when a frame has odd length.
- ADDR_W, 27: width of ioctl_addr.

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE
- index  in  8  frame index; latched on accepted start
- s_valid  in  1  byte valid
- s_ready  out  1  byte accepted when s_valid && s_ready
- s_data  in  8  byte
- s_last  in  1  marks final byte of frame
- ioctl_download  out  1  frame-active
- ioctl_index  out  8  latched index
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_W  byte address of current word (always even)
- ioctl_dout  out  16  word; first byte in [7:0], second byte in [15:8]
- ioctl_wait  in  1  responder back-pressure
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on the cycle ioctl_download falls
- checksum  out  16  see Optional Feature

Behaviour:
- Reset (synchronous, any state, mid-frame included): state returns to IDLE. Every output is 0 on the next cycle: s_ready, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, busy, done, checksum. A partially packed word is discarded.
- Registered outputs except s_ready, which is a combinational decode: s_ready = (state==LO || state==HI).
- States IDLE, SETUP, LO, HI, WRITE, GAP, TAIL.
- IDLE: on start, latch index. Next cycle ioctl_download=1, ioctl_index=index, ioctl_addr=0. Go to SETUP.
- SETUP: counts SETUP_CYCLES, then goes to LO.
- LO, on handshake: ioctl_dout[7:0]=s_data.
  - If s_last: ioctl_dout[15:8]=PAD_BYTE, set last flag, go to WRITE.
  - Otherwise go to HI.
- HI, on handshake: ioctl_dout[15:8]=s_data. Last flag = s_last. Go to WRITE.
- WRITE: when ioctl_wait is sampled low, assert ioctl_wr for exactly one cycle (the next cycle) and go to GAP. While ioctl_wait is high, ioctl_wr stays 0 and ioctl_dout/ioctl_addr are held.
- GAP: counts MIN_GAP cycles from the ioctl_wr pulse.
  - ioctl_addr += 2 on the cycle after the ioctl_wr pulse, modulo 2^ADDR_W (wraps to 0).
  - Then go to TAIL if the last flag is set, else to LO.
- TAIL: counts SETUP_CYCLES, then ioctl_download=0 and done=1 for one cycle. ioctl_index holds its value. Go to IDLE.
- start outside IDLE is ignored; the latched index is unchanged.
- s_last in HI completes a word normally; no padding.
- ioctl_dout and ioctl_addr are stable from the WRITE entry until the GAP exit.
- Back-to-back frames: start in the IDLE cycle right after done is accepted; the address restarts at 0.

Optional Feature:
- Macro IOCTL_SENDER_CHECKSUM_EN.
- Defined:
  - checksum is a 16-bit modulo-2^16 sum of every ioctl_dout value on its ioctl_wr cycle, padded word included.
  - Cleared on accepted start.
  - Held stable from done until the next start.
- Undefined: checksum is tied to 16'h0000 and no adder is synthesized.

Decomposition:
- Package ioctl_pkg:
  - state enum typedef
  - IOCTL_ADDR_W=27, IOCTL_DATA_W=16
  - index constants IOCTL_IDX_ROM=8'h00, IOCTL_IDX_NVRAM=8'h01
- Optional sub-module ioctl_word_packer: LO/HI byte assembly, pad and last flag. Everything else stays in ioctl_sender.

Test Plan:
- Even frame: start index=0; bytes 11,22,33,44 (s_last on 44); ioctl_wait=0 → wr at addr 0 dout 16'h2211; wr at addr 2 dout 16'h4433; exactly 2 wr pulses; done one cycle after TAIL; ioctl_download low after.
- Odd frame: bytes AA,BB,CC (s_last on CC) → addr 0 dout 16'hBBAA; addr 2 dout 16'h00CC. Repeat with PAD_BYTE=8'hFF → 16'hFFCC.
- Back-pressure: ioctl_wait high 10 cycles while in WRITE → no wr and s_ready=0 for those cycles; wr fires 1 cycle after wait falls; dout/addr unchanged throughout.
- Reset mid-frame: assert rst_sys after the first wr → next cycle all outputs 0, busy=0. New start index=1 → first wr at addr 0, ioctl_index=8'h01.
- Start while busy: pulse start with index=8'h05 during GAP → ignored; ioctl_index keeps its original value; frame completes normally.
- Checksum (macro defined): words 16'h2211, 16'h4433 → checksum=16'h6644 at done. Words 16'hFFFF, 16'h0002 → 16'h0001 (wrap). Macro undefined → checksum 0 throughout.

Source files
------------

// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared types and constants for the ioctl download sender
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 27;
    localparam int IOCTL_DATA_W = 16;

    localparam logic [7:0] IOCTL_IDX_ROM   = 8'h00;
    localparam logic [7:0] IOCTL_IDX_NVRAM = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_GAP,
        ST_TAIL
    } ioctl_state_e;

endpackage

// File: rtl/ioctl_word_packer.sv
// rtl/ioctl_word_packer.sv - little-endian byte-to-word assembly with odd-length pad
//
// Ports:
//   clk_sys, rst_sys : clock, synchronous active-high reset (clears word and flag)
//   load_lo_i        : accept data_i as the low byte of a new word
//   load_hi_i        : accept data_i as the high byte of the current word
//   data_i           : incoming byte
//   last_i           : incoming byte is the final byte of the frame
//   word_o           : assembled word (first byte in [7:0])
//   last_o           : assembled word is the final word of the frame
module ioctl_word_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        load_lo_i,
    input  logic        load_hi_i,
    input  logic [7:0]  data_i,
    input  logic        last_i,
    output logic [15:0] word_o,
    output logic        last_o
);

    logic [15:0] word_q, word_d;
    logic        last_q, last_d;

    always_comb begin
        word_d = word_q;
        last_d = last_q;
        if (load_lo_i) begin
            word_d[7:0] = data_i;
            last_d      = last_i;
            // A frame ending on a low byte still produces a full word.
            if (last_i) begin
                word_d[15:8] = PAD_BYTE;
            end
        end else if (load_hi_i) begin
            word_d[15:8] = data_i;
            last_d       = last_i;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            last_q <= last_d;
        end
    end

    assign word_o = word_q;
    assign last_o = last_q;

endmodule

// File: rtl/ioctl_sender.sv
// rtl/ioctl_sender.sv - initiator for the 16-bit ioctl download bus
//
// Optional feature macro: IOCTL_SENDER_CHECKSUM_EN (running 16-bit word sum).
//
// Ports:
//   clk_sys, rst_sys        : clock, synchronous active-high reset
//   start, index            : frame request (honoured in IDLE only) and its index
//   s_valid/s_ready/s_data/s_last : byte stream input
//   ioctl_download          : frame active
//   ioctl_index             : latched frame index
//   ioctl_wr                : one-cycle write strobe
//   ioctl_addr              : even byte address of the current word
//   ioctl_dout              : current word, first byte in [7:0]
//   ioctl_wait              : responder back-pressure
//   busy                    : not idle
//   done                    : pulse on the cycle ioctl_download falls
//   checksum                : sum of written words (zero when feature disabled)
module ioctl_sender
    import ioctl_pkg::*;
#(
    parameter int         SETUP_CYCLES = 4,
    parameter int         MIN_GAP      = 2,
    parameter logic [7:0] PAD_BYTE     = 8'h00,
    parameter int         ADDR_W       = IOCTL_ADDR_W
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic                    start,
    input  logic [7:0]              index,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic                    ioctl_download,
    output logic [7:0]              ioctl_index,
    output logic                    ioctl_wr,
    output logic [ADDR_W-1:0]       ioctl_addr,
    output logic [IOCTL_DATA_W-1:0] ioctl_dout,
    input  logic                    ioctl_wait,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             checksum
);

    ioctl_state_e      state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              download_q, download_d;
    logic [7:0]        index_q, index_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    logic              load_lo;
    logic              load_hi;
    logic              word_last;
    logic              start_ok;
    logic              write_go;

    assign s_ready  = (state_q == ST_LO) || (state_q == ST_HI);
    assign load_lo  = (state_q == ST_LO) && s_valid;
    assign load_hi  = (state_q == ST_HI) && s_valid;
    assign start_ok = (state_q == ST_IDLE) && start;
    assign write_go = (state_q == ST_WRITE) && !ioctl_wait;

    ioctl_word_packer #(
        .PAD_BYTE (PAD_BYTE)
    ) u_packer (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .load_lo_i (load_lo),
        .load_hi_i (load_hi),
        .data_i    (s_data),
        .last_i    (s_last),
        .word_o    (ioctl_dout),
        .last_o    (word_last)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        download_d = download_q;
        index_d    = index_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d    = index;
                    download_d = 1'b1;
                    addr_d     = '0;
                    cnt_d      = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LO: begin
                if (s_valid) begin
                    state_d = s_last ? ST_WRITE : ST_HI;
                end
            end
            ST_HI: begin
                if (s_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!ioctl_wait) begin
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // The first GAP cycle is the strobe cycle; the address moves
                // only once the responder has seen the current one.
                if (cnt_q == 16'd0) begin
                    addr_d = addr_q + ADDR_W'(2);
                end
                if (cnt_q == 16'(MIN_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = word_last ? ST_TAIL : ST_LO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_TAIL: begin
                if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
                    cnt_d      = '0;
                    download_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            download_q <= 1'b0;
            index_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            download_q <= download_d;
            index_q    <= index_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
        end
    end

`ifdef IOCTL_SENDER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Accumulate on the edge that raises ioctl_wr so the sum already covers
    // the word being strobed; it then holds until the next accepted start.
    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (write_go) begin
            sum_d = sum_q + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_ok;
    assign unused_ok = start_ok ^ write_go;
    assign checksum  = 16'h0000;
`endif

    assign ioctl_download = download_q;
    assign ioctl_index    = index_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_ioctl_sender.sv
// tb/tb_ioctl_sender.sv - self-checking bench for ioctl_sender
module tb_ioctl_sender;

    localparam int         SETUP = 4;
    localparam int         GAPC  = 2;
    localparam logic [7:0] PAD   = 8'h00;
    localparam int         AW    = 27;
`ifdef IOCTL_SENDER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          start   = 1'b0;
    logic [7:0]    index   = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data  = 8'h00;
    logic          s_last  = 1'b0;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          ioctl_wait;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;

    logic wait_rnd     = 1'b0;
    logic wait_force   = 1'b0;
    logic wait_rand_en = 1'b0;
    assign ioctl_wait = wait_rand_en ? wait_rnd : wait_force;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        #1 wait_rnd = ($urandom % 3) == 0;
    end

    ioctl_sender #(
        .SETUP_CYCLES (SETUP),
        .MIN_GAP      (GAPC),
        .PAD_BYTE     (PAD),
        .ADDR_W       (AW)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .start          (start),
        .index          (index),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .done           (done),
        .checksum       (checksum)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame bytes -> expected word/address sequence and sum.
    logic [7:0]    frame_q[$];
    logic [15:0]   exp_dout_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_index = 8'h00;
    logic [15:0]   exp_sum   = 16'h0000;

    int          wcount   = 0;
    int          done_cnt = 0;
    logic [15:0] wlog[0:7];
    bit          mon_en    = 1'b0;
    logic        prev_wait = 1'b0;
    logic        wr_prev   = 1'b0;
    logic        done_prev = 1'b0;

    task automatic build_expect();
        logic [7:0] lo, hi;
        exp_dout_q.delete();
        exp_addr_q.delete();
        exp_sum = 16'h0000;
        for (int k = 0; 2 * k < frame_q.size(); k++) begin
            lo = frame_q[2 * k];
            hi = (2 * k + 1 < frame_q.size()) ? frame_q[2 * k + 1] : PAD;
            exp_dout_q.push_back({hi, lo});
            exp_addr_q.push_back(AW'(2 * k));
            exp_sum = exp_sum + {hi, lo};
        end
    endtask

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (ioctl_wr) begin
                check("wr_after_wait_low", 32'(prev_wait), 32'd0);
                check("wr_single_cycle", 32'(wr_prev), 32'd0);
                if (exp_dout_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_extra: unexpected write addr %0h dout %0h", ioctl_addr, ioctl_dout);
                end else begin
                    check("wr_addr", 32'(ioctl_addr), 32'(exp_addr_q.pop_front()));
                    check("wr_dout", 32'(ioctl_dout), 32'(exp_dout_q.pop_front()));
                    check("wr_index", 32'(ioctl_index), 32'(exp_index));
                end
                wlog[wcount % 8] = ioctl_dout;
                wcount++;
            end
            if (done) begin
                check("done_download_low", 32'(ioctl_download), 32'd0);
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_checksum", 32'(checksum), CSUM_EN ? 32'(exp_sum) : 32'd0);
                check("done_words_left", 32'(exp_dout_q.size()), 32'd0);
                check("done_single_cycle", 32'(done_prev), 32'd0);
                done_cnt++;
            end
            if (s_ready) begin
                check("ready_implies_download", 32'(ioctl_download), 32'd1);
            end
        end
        prev_wait = ioctl_wait;
        wr_prev   = ioctl_wr;
        done_prev = done;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_download"}, 32'(ioctl_download), 32'd0);
        check({tag, "_index"}, 32'(ioctl_index), 32'd0);
        check({tag, "_wr"}, 32'(ioctl_wr), 32'd0);
        check({tag, "_addr"}, 32'(ioctl_addr), 32'd0);
        check({tag, "_dout"}, 32'(ioctl_dout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] idx);
        build_expect();
        exp_index = idx;
        wcount    = 0;
        start     = 1'b1;
        index     = idx;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        index = 8'($urandom);
    endtask

    task automatic feed(input int n);
        int  i = 0;
        int  budget = 0;
        logic rdy;
        while (i < n && budget < 2000) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = frame_q[i];
            s_last  = (i == frame_q.size() - 1);
            @(negedge clk_sys);
            rdy = s_ready;
            @(posedge clk_sys);
            #1;
            if (s_valid && rdy) i++;
            budget++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
        if (i < n) check("feed_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int budget = 0;
        while (done_cnt == d0 && budget < 500) begin
            @(negedge clk_sys);
            budget++;
        end
        if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_wr();
        int budget = 0;
        do begin
            @(negedge clk_sys);
            budget++;
        end while (!ioctl_wr && budget < 500);
        if (!ioctl_wr) check("wr_timeout", 32'(ioctl_wr), 32'd1);
    endtask

    task automatic post_checks(input int words);
        @(negedge clk_sys);
        check("post_download_low", 32'(ioctl_download), 32'd0);
        check("post_word_count", 32'(wcount), 32'(words));
        check("post_index_held", 32'(ioctl_index), 32'(exp_index));
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int len;

        repeat (3) @(posedge clk_sys);
        #1 rst_sys = 1'b0;
        @(negedge clk_sys);
        check_all_zero("reset");
        mon_en = 1'b1;
        @(posedge clk_sys);
        #1;

        // Even frame.
        frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_frame(8'h00);
        feed(4);
        wait_done();
        check("even_w0", 32'(wlog[0]), 32'h2211);
        check("even_w1", 32'(wlog[1]), 32'h4433);
        check("even_sum", 32'(checksum), CSUM_EN ? 32'h6644 : 32'h0);
        post_checks(2);

        // Odd frame, padded high byte.
        frame_q = '{8'hAA, 8'hBB, 8'hCC};
        start_frame(8'h01);
        feed(3);
        wait_done();
        check("odd_w0", 32'(wlog[0]), 32'hBBAA);
        check("odd_w1", 32'(wlog[1]), 32'h00CC);
        post_checks(2);

        // Checksum wrap.
        frame_q = '{8'hFF, 8'hFF, 8'h02, 8'h00};
        start_frame(8'h02);
        feed(4);
        wait_done();
        check("wrap_sum", 32'(checksum), CSUM_EN ? 32'h0001 : 32'h0);
        post_checks(2);

        // Back-pressure held for 10 cycles in WRITE.
        frame_q    = '{8'h5A, 8'hA5};
        wait_force = 1'b1;
        start_frame(8'h03);
        feed(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_sys);
            check("bp_no_wr", 32'(ioctl_wr), 32'd0);
            check("bp_no_ready", 32'(s_ready), 32'd0);
            check("bp_dout_held", 32'(ioctl_dout), 32'hA55A);
            check("bp_addr_held", 32'(ioctl_addr), 32'd0);
            @(posedge clk_sys);
            #1;
        end
        wait_force = 1'b0;
        @(negedge clk_sys);
        check("bp_wr_not_yet", 32'(ioctl_wr), 32'd0);
        @(posedge clk_sys);
        #1;
        @(negedge clk_sys);
        check("bp_wr_fires", 32'(ioctl_wr), 32'd1);
        wait_done();
        post_checks(1);

        // Reset after the first write of a frame.
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        start_frame(8'h07);
        feed(2);
        wait_wr();
        @(posedge clk_sys);
        #1 rst_sys = 1'b1;
        @(posedge clk_sys);
        #1 rst_sys = 1'b0;
        @(negedge clk_sys);
        check_all_zero("midrst");
        @(posedge clk_sys);
        #1;
        frame_q = '{8'h9C, 8'h3E, 8'h71};
        start_frame(8'h01);
        feed(3);
        wait_done();
        check("midrst_w0", 32'(wlog[0]), 32'h3E9C);
        check("midrst_index", 32'(ioctl_index), 32'h01);
        post_checks(2);

        // Start pulse during GAP must be ignored.
        frame_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        start_frame(8'h3C);
        fork
            feed(6);
            begin
                wait_wr();
                start = 1'b1;
                index = 8'h05;
                @(posedge clk_sys);
                #1;
                start = 1'b0;
            end
        join
        wait_done();
        check("busy_start_index", 32'(ioctl_index), 32'h3C);
        post_checks(3);

        // Randomized frames with random back-pressure, back to back.
        wait_rand_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 9);
            frame_q.delete();
            for (int b = 0; b < len; b++) frame_q.push_back(8'($urandom));
            start_frame(8'($urandom));
            feed(len);
            wait_done();
            post_checks((len + 1) / 2);
        end
        wait_rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
